// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, writeback, issue and clear signals between the pipeline and
// the scoreboarded register file.
interface regfile_scoreboard_if #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2
);
  localparam int unsigned AW = $clog2(REG_COUNT);

  logic [READ_PORTS*AW-1:0]        rs_addr;
  logic [READ_PORTS*REG_WIDTH-1:0] rs_data;
  logic [READ_PORTS-1:0]           rs_pending;
  logic                            wr_en;
  logic [AW-1:0]                   wr_addr;
  logic [REG_WIDTH-1:0]            wr_data;
  logic                            iss_en;
  logic [AW-1:0]                   iss_rd;
  logic                            clr_req;
  logic                            clr_busy;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, clr_req,
    input  rs_data, rs_pending, clr_busy
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, clr_req,
    output rs_data, rs_pending, clr_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-first bypass, per-register pending bits and
// a one-entry-per-cycle clear sweep so the storage array needs no reset.
module regfile_scoreboard #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);
  localparam int unsigned AW = $clog2(REG_COUNT);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_idx_q, clr_idx_d;
  logic                   busy_q, busy_d;
  logic [REG_COUNT-1:1]   pend_q, pend_d;
  logic [REG_WIDTH-1:0]   regs [1:REG_COUNT-1];

  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [REG_WIDTH-1:0]   mem_wdata;

  logic [READ_PORTS*REG_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]           rd_pend;
  logic [AW-1:0]                   ra;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= AW'(1);
      busy_q    <= 1'b1;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
    end
  end

  // The sweep and writeback share a single storage write port; entry 0 is never addressed.
  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_addr  = bus.wr_addr;
    mem_wdata = bus.wr_data;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = !reset;
        mem_addr  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(REG_COUNT - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d   = S_CLEAR;
          clr_idx_d = AW'(1);
          busy_d    = 1'b1;
          pend_d    = '0;
        end else begin
          // Issue is applied after the write clear so a new producer wins.
          if (bus.wr_en && (bus.wr_addr != '0)) begin
            mem_we               = !reset;
            pend_d[bus.wr_addr]  = 1'b0;
          end
          if (bus.iss_en && (bus.iss_rd != '0)) pend_d[bus.iss_rd] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    for (int unsigned i = 0; i < READ_PORTS; i++) begin
      ra = bus.rs_addr[i*AW +: AW];
      if (busy_q || (ra == '0)) begin
        rd_data[i*REG_WIDTH +: REG_WIDTH] = '0;
        rd_pend[i]                        = 1'b0;
      end else if (bus.wr_en && (bus.wr_addr == ra)) begin
        rd_data[i*REG_WIDTH +: REG_WIDTH] = bus.wr_data;
        rd_pend[i]                        = 1'b0;
      end else begin
        rd_data[i*REG_WIDTH +: REG_WIDTH] = regs[ra];
        rd_pend[i]                        = pend_q[ra];
      end
    end
  end

  assign bus.rs_data    = rd_data;
  assign bus.rs_pending = rd_pend;
  assign bus.clr_busy   = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a driver issues per-cycle stimulus and queues the expected
// read-port and busy values from an abstract model; a monitor checks them.
module tb_regfile_scoreboard;
  localparam int unsigned W  = 32;
  localparam int unsigned RC = 32;
  localparam int unsigned RP = 2;
  localparam int unsigned AW = $clog2(RC);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.REG_WIDTH(W), .REG_COUNT(RC), .READ_PORTS(RP)) bus ();

  regfile_scoreboard #(.REG_WIDTH(W), .REG_COUNT(RC), .READ_PORTS(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          busy;
    logic [RP*W-1:0] data;
    logic [RP-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Abstract model: a sweep simply zeroes everything and lasts RC-1 cycles.
  logic [W-1:0] m_regs [RC];
  bit           m_pend [RC];
  int           m_busy_left = 0;
  bit           m_valid = 0;

  task automatic model_step(input bit rst, input bit wen, input int waddr,
                            input logic [W-1:0] wdata, input bit ien,
                            input int ird, input bit creq);
    if (rst || (m_busy_left == 0 && creq)) begin
      m_busy_left = RC - 1;
      for (int i = 0; i < RC; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (wen && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 0;
      end
      if (ien && ird != 0) m_pend[ird] = 1;
    end
  endtask

  task automatic cyc(input bit rst, input bit wen, input int waddr,
                     input logic [W-1:0] wdata, input bit ien, input int ird,
                     input bit creq, input int a0, input int a1);
    exp_t e;
    int   a;
    reset       = rst;
    bus.wr_en   = wen;
    bus.wr_addr = AW'(waddr);
    bus.wr_data = wdata;
    bus.iss_en  = ien;
    bus.iss_rd  = AW'(ird);
    bus.clr_req = creq;
    bus.rs_addr[0 +: AW]  = AW'(a0);
    bus.rs_addr[AW +: AW] = AW'(a1);
    if (m_valid) begin
      e.busy = (m_busy_left > 0);
      e.data = '0;
      e.pend = '0;
      for (int p = 0; p < int'(RP); p++) begin
        a = (p == 0) ? a0 : a1;
        if (e.busy || a == 0) begin
          e.data[p*W +: W] = '0;
          e.pend[p]        = 1'b0;
        end else if (wen && waddr == a) begin
          e.data[p*W +: W] = wdata;
          e.pend[p]        = 1'b0;
        end else begin
          e.data[p*W +: W] = m_regs[a];
          e.pend[p]        = m_pend[a];
        end
      end
      q.push_back(e);
    end
    @(posedge clk);
    model_step(rst, wen, waddr, wdata, ien, ird, creq);
    m_valid = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(0, 0, 0, '0, 0, 0, 0, int'($urandom_range(0, RC-1)), int'($urandom_range(0, RC-1)));
  endtask

  task automatic rd(input int a0, input int a1);
    cyc(0, 0, 0, '0, 0, 0, 0, a0, a1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.clr_busy !== e.busy) begin
        errors++;
        $display("FAIL clr_busy t=%0t got=%0b exp=%0b", $time, bus.clr_busy, e.busy);
      end
      for (int p = 0; p < int'(RP); p++) begin
        checks++;
        if (bus.rs_data[p*W +: W] !== e.data[p*W +: W]) begin
          errors++;
          $display("FAIL rs_data%0d t=%0t addr=%0d got=%h exp=%h", p, $time,
                   bus.rs_addr[p*AW +: AW], bus.rs_data[p*W +: W], e.data[p*W +: W]);
        end
        checks++;
        if (bus.rs_pending[p] !== e.pend[p]) begin
          errors++;
          $display("FAIL rs_pending%0d t=%0t addr=%0d got=%0b exp=%0b", p, $time,
                   bus.rs_addr[p*AW +: AW], bus.rs_pending[p], e.pend[p]);
        end
      end
    end
  end

  initial begin
    int wa, ia, drain;
    bus.rs_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 0; bus.iss_rd = '0; bus.clr_req = 0;
    #1;

    // Reset, full sweep, then every address reads zero / not pending.
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'h1, 1, 3, 0, 3, 0);
    idle(RC - 1);
    for (int a = 0; a < int'(RC); a += 2) rd(a, a + 1);

    // Write bypass then storage read.
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 6);
    rd(5, 5);

    // Issue marks pending next cycle; writeback masks and clears it.
    cyc(0, 0, 0, '0, 1, 7, 0, 7, 0);
    rd(7, 5);
    cyc(0, 1, 7, 32'h12, 0, 0, 0, 7, 7);
    rd(7, 0);

    // Same-cycle issue and write: new producer wins; x0 ignores both.
    cyc(0, 1, 9, 32'h55, 1, 9, 0, 9, 0);
    rd(9, 9);
    cyc(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    rd(0, 9);

    // Soft clear drops a same-cycle write and wipes data and pending.
    cyc(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, '0, 1, 4, 0, 3, 4);
    rd(3, 4);
    cyc(0, 1, 3, 32'h1234_5678, 0, 0, 1, 3, 4);
    idle(RC - 1);
    rd(3, 4);

    // Reset mid-sweep restarts the full window; writes while busy are dropped.
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, '0, 0, 0, 0, 2, 0);
    cyc(0, 1, 2, 32'h1, 1, 2, 0, 2, 2);
    idle(RC - 3);
    rd(2, 1);
    rd(2, 2);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      wa = int'($urandom_range(0, RC-1));
      ia = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, RC-1));
      cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1), wa, W'($urandom),
          $urandom_range(0, 1), ia, ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, RC-1)),
          ($urandom_range(0, 2) == 0) ? ia : int'($urandom_range(0, RC-1)));
    end

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain remaining=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the core's integer register file. It provides N combinational read ports with write-first bypass and a per-register pending (scoreboard) bit for hazard detection. It also has a sequential clear engine that zeroes the storage array one entry per cycle after reset or on request, so the array itself needs no reset. It sits between decode/issue (reads, pending checks, issue marking) and writeback (writes, pending clear).

## Interface
- REG_WIDTH, 32, data width of each register
- REG_COUNT, 32, number of architectural registers; power of two, ≥ 2; entry 0 hardwired to zero
- READ_PORTS, 2, number of independent read ports; ≥ 1
- AW (derived, not overridable), $clog2(REG_COUNT), address width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rs_addr  in  READ_PORTS*AW  packed read addresses; port i at [i*AW +: AW]
- rs_data  out  READ_PORTS*REG_WIDTH  packed read data; port i at [i*REG_WIDTH +: REG_WIDTH]
- rs_pending  out  READ_PORTS  pending bit for each read address
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback destination
- wr_data  in  REG_WIDTH  writeback data
- iss_en  in  1  issue strobe; marks iss_rd pending
- iss_rd  in  AW  destination of issuing instruction
- clr_req  in  1  start a soft clear sweep (single-cycle pulse is sufficient)
- clr_busy  out  1  registered; high while the sweep is in progress

## Operation
- Storage: REG_COUNT-1 entries (1..REG_COUNT-1), no reset. Entry 0 is not stored.
- Pending: REG_COUNT-1 bits, synchronously reset to 0.
- FSM states: CLEAR, IDLE. Counter clr_idx is AW bits.
- reset=1: next state CLEAR, clr_idx←1, all pending←0, clr_busy←1.
- CLEAR, each edge with reset=0:
  - regs[clr_idx]←0, clr_idx←clr_idx+1.
  - If clr_idx==REG_COUNT-1 on that edge: state←IDLE, clr_busy←0.
- IDLE with clr_req=1: state←CLEAR, clr_idx←1, all pending←0, clr_busy←1. In that same cycle, wr_en and iss_en are ignored.
- CLEAR ignores clr_req, wr_en and iss_en (no storage or pending change from them).
- IDLE, write: wr_en=1 with wr_addr≠0 sets regs[wr_addr]←wr_data and pending[wr_addr]←0.
- IDLE, issue: iss_en=1 with iss_rd≠0 sets pending[iss_rd]←1.
- Same rd issued and written in one cycle: data is written and pending ends 1 (the new producer wins).
- Writes and issues to address 0 are discarded.
- Read port i, combinational, priority order:
  1. clr_busy=1 → data 0, pending 0.
  2. rs_addr_i==0 → data 0, pending 0.
  3. wr_en=1 and wr_addr==rs_addr_i → data wr_data, pending 0 (bypass).
  4. Otherwise → regs[rs_addr_i], pending[rs_addr_i].
- iss_en does not bypass into rs_pending; it takes effect the following cycle.
- All read ports are independent. Any number of ports may use the same address.

## Timing
- Reset values: clr_busy=1, all pending=0. rs_data and rs_pending read 0 while clr_busy=1.
- After reset falls, clr_busy stays high for exactly REG_COUNT-1 rising edges (31 at default), then drops.
- clr_req sampled in IDLE: clr_busy rises at the next edge and stays high for REG_COUNT-1 edges.
- Write latency: stored on the edge; visible the same cycle via bypass; visible from storage the next cycle.
- Pending set latency: 1 edge after iss_en. Pending clear: combinationally masked in the write cycle, stored on the edge.
- Reset asserted mid-sweep restarts the sweep at index 1, with the full REG_COUNT-1 cycles.
- Entry 0 has no dependence on state or cycle.

## Test plan
- Reset then 31 idle cycles (defaults) → clr_busy high for exactly 31 edges after reset falls. All ports then read 0 / pending 0 for every address 0..31.
- wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rs_addr0=5 same cycle → rs_data0=0xDEADBEEF, rs_pending0=0. Next cycle with wr_en=0 → still 0xDEADBEEF.
- iss_en=1, iss_rd=7 → next cycle rs_pending for x7 is 1. Then wr_en to x7 with data 0x12 → rs_pending 0 and data 0x12 in that cycle; stored pending 0 afterwards.
- Same cycle iss_en/iss_rd=9 and wr_en/wr_addr=9 data 0x55 → next cycle x9 reads 0x55 with pending=1. Write and issue to x0 → x0 reads 0, pending 0.
- Load x3=0xA5A5A5A5, mark x4 pending, pulse clr_req together with wr_en to x3 → write dropped, clr_busy high 31 cycles with reads 0. After the sweep, x3=0 and x4 pending=0.
- Reset asserted at sweep cycle 10 for 1 cycle → a fresh 31-cycle busy window follows. A write during busy to x2 (0x1) is ignored, so x2 reads 0 afterwards.
